// File: rtl/histogram_pkg.sv
// Shared widths, default bin counts and FSM encoding
// for the histogram peak reader.
package histogram_pkg;

    localparam int DEF_X_BINS = 240;
    localparam int DEF_Y_BINS = 180;
    localparam int BIN_W      = 8;
    localparam int IDX_W      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        CLEAR  = 2'd2,
        RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/histogram_peak_reader_peak_tracker.sv
// Running arg-max over one streamed histogram projection.
// Ties keep the lowest index; beats past NBINS are dropped.
module peak_tracker
    import histogram_pkg::*;
#(
    parameter int NBINS = DEF_X_BINS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             valid,
    input  logic [BIN_W-1:0] count,
    output logic [IDX_W-1:0] peakIdx,
    output logic [BIN_W-1:0] peakCount,
    output logic             done
);

    // one extra bit so a full 256-bin stream can still signal done
    logic [IDX_W:0] idx;

    assign done = (idx == (IDX_W+1)'(NBINS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            peakIdx   <= '0;
            peakCount <= '0;
        end else if (clr) begin
            idx       <= '0;
            peakIdx   <= '0;
            peakCount <= '0;
        end else if (valid && !done) begin
            idx <= idx + 1'b1;
            if (count > peakCount) begin
                peakIdx   <= idx[IDX_W-1:0];
                peakCount <= count;
            end
        end
    end

endmodule

// File: rtl/histogram_peak_reader.sv
// Reads X/Y projection histograms after each frame, finds their
// peaks, clears the histogram and hands the result downstream.
module histogram_peak_reader
    import histogram_pkg::*;
#(
    parameter int X_BINS   = DEF_X_BINS,
    parameter int Y_BINS   = DEF_Y_BINS,
    parameter int PEAK_MIN = 1,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fullImageDone,
    output logic             readHistogram,
    input  logic [BIN_W-1:0] xHistogramOut,
    input  logic             xValid,
    input  logic [BIN_W-1:0] yHistogramOut,
    input  logic             yValid,
    output logic             clearHistogram,
    input  logic             histogramCleared,
    output logic [IDX_W-1:0] xPeak,
    output logic [IDX_W-1:0] yPeak,
    output logic [BIN_W-1:0] xPeakCount,
    output logic [BIN_W-1:0] yPeakCount,
    output logic             peakFound,
    output logic             timeoutErr,
    output logic             resultValid,
    input  logic             resultAck,
    output logic             busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          nextState;
    logic [WD_W-1:0] wdog;
    logic            wdFire;
    logic            startTxn;
    logic            readTimeout;
    logic            clrTimeout;
    logic            xDone;
    logic            yDone;
    logic            xBeat;
    logic            yBeat;

    assign wdFire = (wdog == WD_W'(TIMEOUT - 1));
    assign xBeat  = xValid && (state == READ);
    assign yBeat  = yValid && (state == READ);

    peak_tracker #(.NBINS(X_BINS)) uXTrk (
        .clk       (clk),
        .reset     (reset),
        .clr       (startTxn),
        .valid     (xBeat),
        .count     (xHistogramOut),
        .peakIdx   (xPeak),
        .peakCount (xPeakCount),
        .done      (xDone)
    );

    peak_tracker #(.NBINS(Y_BINS)) uYTrk (
        .clk       (clk),
        .reset     (reset),
        .clr       (startTxn),
        .valid     (yBeat),
        .count     (yHistogramOut),
        .peakIdx   (yPeak),
        .peakCount (yPeakCount),
        .done      (yDone)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState   = state;
        startTxn    = 1'b0;
        readTimeout = 1'b0;
        clrTimeout  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fullImageDone) begin
                    nextState = READ;
                    startTxn  = 1'b1;
                end
            end
            READ: begin
                if (xDone && yDone) begin
                    nextState = CLEAR;
                end else if (wdFire) begin
                    nextState   = CLEAR;
                    readTimeout = 1'b1;
                end
            end
            CLEAR: begin
                if (histogramCleared) begin
                    nextState = RESULT;
                end else if (wdFire) begin
                    nextState  = RESULT;
                    clrTimeout = 1'b1;
                end
            end
            RESULT: begin
                if (resultAck) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // watchdog restarts on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog <= '0;
        end else if (state != nextState) begin
            wdog <= '0;
        end else if (state == READ || state == CLEAR) begin
            wdog <= wdog + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peakFound  <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            if (startTxn) begin
                peakFound  <= 1'b0;
                timeoutErr <= 1'b0;
            end
            if (readTimeout || clrTimeout) timeoutErr <= 1'b1;
            if (state == CLEAR && nextState == RESULT) begin
                peakFound <= !clrTimeout
                          && (xPeakCount >= BIN_W'(PEAK_MIN))
                          && (yPeakCount >= BIN_W'(PEAK_MIN));
            end
        end
    end

    assign readHistogram  = (state == READ);
    assign clearHistogram = (state == CLEAR);
    assign resultValid    = (state == RESULT);
    assign busy           = (state != IDLE);

endmodule
